// File: rtl/fuzzy_pkg.sv
// ============================================================================
// Module      : fuzzy_pkg
// Description : Shared types, constants and Q15 helpers for the fuzzy
//               inference sequencer and its divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fuzzy_pkg;

    localparam int N_TERMS_DEF = 3;
    localparam int N_RULES_DEF = 9;
    localparam int TIDX_W_DEF  = $clog2(N_TERMS_DEF);
    localparam int DIV_QBITS   = 9;

    // Rule table entry layout for the default term count (MSB first).
    typedef struct packed {
        logic                  en;
        logic [TIDX_W_DEF-1:0] ia;
        logic [TIDX_W_DEF-1:0] ib;
        logic signed [7:0]     cons;
    } rule_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

    // Minimum of two Q1.15 degrees; a negative result is clamped to zero so
    // firing strengths are never negative.
    function automatic logic [15:0] q15_min(input logic [15:0] a, input logic [15:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] m;
        sa = a;
        sb = b;
        m  = (sa < sb) ? sa : sb;
        return m[15] ? 16'd0 : m;
    endfunction

    // Saturate a signed value into the int8 range.
    function automatic logic signed [7:0] sat_s8(input logic signed [15:0] v);
        if (v > 16'sd127)
            return 8'sd127;
        else if (v < -16'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fuzzy_seq_divider.sv
// ============================================================================
// Module      : fuzzy_seq_divider
// Description : Restoring divider, one quotient bit per cycle, QBITS cycles.
//               The caller guarantees dividend < divisor * 2**QBITS.
//               o_done is high during the last iteration cycle and
//               o_quotient carries the final quotient in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fuzzy_seq_divider
    import fuzzy_pkg::*;
#(
    parameter int QBITS = DIV_QBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [31:0]      i_dividend,
    input  logic [23:0]      i_divisor,
    output logic             o_done,
    output logic [QBITS-1:0] o_quotient
);

    localparam int DW    = 24 + QBITS;
    localparam int CNT_W = $clog2(QBITS);

    logic [DW-1:0]    r_rem;
    logic [DW-1:0]    r_dsh;
    logic [QBITS-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    logic             w_ge;
    logic [QBITS-1:0] w_q_nx;

    assign w_ge       = (r_rem >= r_dsh);
    assign w_q_nx     = {r_q[QBITS-2:0], w_ge};
    assign o_done     = r_active && (r_cnt == CNT_W'(QBITS - 1));
    assign o_quotient = w_q_nx;

    // Subtract the shifted divisor when it fits, then shift it down one bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_dsh    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_rem    <= DW'(i_dividend);
            r_dsh    <= DW'({i_divisor, {(QBITS-1){1'b0}}});
            r_q      <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (w_ge)
                r_rem <= r_rem - r_dsh;
            r_dsh <= r_dsh >> 1;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (o_done)
                r_active <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fuzzy_rule_seq.sv
// ============================================================================
// Module      : fuzzy_rule_seq
// Description : Fuzzy inference sequencer. Captures one sample of Q1.15
//               membership degrees, walks the rule table one rule per cycle
//               (strength = min of two antecedents), accumulates weighted
//               consequents and divides to an int8 crisp output.
//               Optional macro FUZZY_SEQ_ROUND_EN: round half away from zero
//               instead of truncating toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fuzzy_rule_seq
    import fuzzy_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int N_RULES = N_RULES_DEF,
    localparam int TIDX_W = $clog2(N_TERMS),
    localparam int IDX_W  = $clog2(N_RULES),
    localparam int RULE_W = 1 + 2*TIDX_W + 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*N_TERMS-1:0] mu_a,
    input  logic [16*N_TERMS-1:0] mu_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_s8,
    output logic                 out_nofire,
    output logic                 busy,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [RULE_W-1:0]    cfg_data,
    output logic                 cfg_err
);

    seq_state_e          r_state;
    logic [RULE_W-1:0]   r_table [N_RULES];
    logic [16*N_TERMS-1:0] r_mu_a;
    logic [16*N_TERMS-1:0] r_mu_b;
    logic [IDX_W-1:0]    r_idx;
    logic [23:0]         r_sum_w;
    logic signed [31:0]  r_sum_ws;
    logic                r_neg;
    logic                r_out_valid;
    logic signed [7:0]   r_out_s8;
    logic                r_nofire;
    logic                r_cfg_err;

    logic [RULE_W-1:0]   w_rule;
    logic                w_en;
    logic [TIDX_W-1:0]   w_ia;
    logic [TIDX_W-1:0]   w_ib;
    logic signed [7:0]   w_cons;
    logic [15:0]         w_deg_a;
    logic [15:0]         w_deg_b;
    logic                w_ia_ok;
    logic                w_ib_ok;
    logic [15:0]         w_w;
    logic signed [31:0]  w_prod;
    logic [23:0]         w_sum_w_nx;
    logic signed [31:0]  w_sum_ws_nx;
    logic [31:0]         w_mag;
    logic [31:0]         w_dividend;
    logic                w_last;
    logic                w_div_start;
    logic                w_div_done;
    logic [DIV_QBITS-1:0] w_q;
    logic signed [15:0]  w_q_s;

    assign in_ready   = (r_state == S_IDLE) && !cfg_we;
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_s8     = r_out_s8;
    assign out_nofire = r_nofire;
    assign cfg_err    = r_cfg_err;

    assign w_rule = r_table[r_idx];
    assign w_en   = w_rule[RULE_W-1];
    assign w_ia   = w_rule[RULE_W-2 -: TIDX_W];
    assign w_ib   = w_rule[8 +: TIDX_W];
    assign w_cons = w_rule[7:0];

    // Select the antecedent degrees; term indices past N_TERMS leave *_ok low.
    always_comb begin
        w_deg_a = '0;
        w_deg_b = '0;
        w_ia_ok = 1'b0;
        w_ib_ok = 1'b0;
        for (int k = 0; k < N_TERMS; k++) begin
            if (w_ia == TIDX_W'(k)) begin
                w_deg_a = r_mu_a[16*k +: 16];
                w_ia_ok = 1'b1;
            end
            if (w_ib == TIDX_W'(k)) begin
                w_deg_b = r_mu_b[16*k +: 16];
                w_ib_ok = 1'b1;
            end
        end
    end

    assign w_w         = (w_en && w_ia_ok && w_ib_ok) ? q15_min(w_deg_a, w_deg_b) : 16'd0;
    assign w_prod      = $signed({16'd0, w_w}) * 32'(w_cons);
    assign w_sum_w_nx  = r_sum_w + 24'(w_w);
    assign w_sum_ws_nx = r_sum_ws + w_prod;
    assign w_mag       = w_sum_ws_nx[31] ? -w_sum_ws_nx : w_sum_ws_nx;
`ifdef FUZZY_SEQ_ROUND_EN
    assign w_dividend  = w_mag + 32'(w_sum_w_nx >> 1);
`else
    assign w_dividend  = w_mag;
`endif
    assign w_last      = (r_idx == IDX_W'(N_RULES - 1));
    // The divider loads the post-update sums on the last EVAL edge so DIV
    // spends exactly DIV_QBITS cycles.
    assign w_div_start = (r_state == S_EVAL) && w_last && (w_sum_w_nx != 24'd0);
    assign w_q_s       = r_neg ? -$signed({7'd0, w_q}) : $signed({7'd0, w_q});

    fuzzy_seq_divider #(
        .QBITS (DIV_QBITS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_sum_w_nx),
        .o_done     (w_div_done),
        .o_quotient (w_q)
    );

    // Rule table writes are accepted only in IDLE and in range; others pulse cfg_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RULES; i++)
                r_table[i] <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (cfg_we) begin
                if ((r_state == S_IDLE) && (int'(cfg_addr) < N_RULES))
                    r_table[cfg_addr] <= cfg_data;
                else
                    r_cfg_err <= 1'b1;
            end
        end
    end

    // Main sequencer: capture, rule walk, divide, hold result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mu_a      <= '0;
            r_mu_b      <= '0;
            r_idx       <= '0;
            r_sum_w     <= '0;
            r_sum_ws    <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_s8    <= '0;
            r_nofire    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !cfg_we) begin
                        r_mu_a   <= mu_a;
                        r_mu_b   <= mu_b;
                        r_sum_w  <= '0;
                        r_sum_ws <= '0;
                        r_idx    <= '0;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_sum_w  <= w_sum_w_nx;
                    r_sum_ws <= w_sum_ws_nx;
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_idx <= '0;
                        r_neg <= w_sum_ws_nx[31];
                        if (w_sum_w_nx == 24'd0) begin
                            r_out_s8    <= '0;
                            r_nofire    <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (w_div_done) begin
                        r_out_s8    <= sat_s8(w_q_s);
                        r_nofire    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fuzzy_rule_seq.sv
// ============================================================================
// Module      : tb_fuzzy_rule_seq
// Description : Self-checking bench for fuzzy_rule_seq: table-driven result
//               vectors plus directed handshake/config/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fuzzy_rule_seq;
    import fuzzy_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] mu_a = '0;
    logic [47:0] mu_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_s8;
    logic        out_nofire;
    logic        busy;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [12:0] cfg_data = '0;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          n_on;
        logic [1:0]  ia;
        logic [1:0]  ib;
        logic signed [7:0] ca;
        logic signed [7:0] cb;
        logic [47:0] ma;
        logic [47:0] mb;
        int          e_trunc;
        int          e_round;
        int          e_nf;
        int          e_lat;
    } vec_t;

    localparam logic [47:0] ALL_MAX = {3{16'd32767}};

    fuzzy_rule_seq #(.N_TERMS(3), .N_RULES(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mu_a       (mu_a),
        .mu_b       (mu_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s8     (out_s8),
        .out_nofire (out_nofire),
        .busy       (busy),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(int n, int ia, int ib, int ca, int cb,
                                 logic [47:0] ma, logic [47:0] mb,
                                 int et, int er, int nf, int lat);
        vec_t v;
        v.n_on = n;  v.ia = 2'(ia); v.ib = 2'(ib);
        v.ca = 8'(ca); v.cb = 8'(cb); v.ma = ma; v.mb = mb;
        v.e_trunc = et; v.e_round = er; v.e_nf = nf; v.e_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input logic [12:0] data);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic accept(input logic [47:0] a, input logic [47:0] b);
        mu_a = a; mu_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns the number of edges since the accept edge at which out_valid rose (-1 on timeout).
    task automatic wait_out(input int base, output int lat);
        lat = -1;
        for (int k = base + 1; k <= 60; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        rule_t r;
        do_reset();
        for (int i = 0; i < v.n_on; i++) begin
            r.en = 1'b1; r.ia = v.ia; r.ib = v.ib;
            r.cons = (i == 0) ? v.ca : v.cb;
            cfg_write(i, r);
        end
        accept(v.ma, v.mb);
        wait_out(0, lat);
        chk($sformatf("vec%0d latency", idx), lat, v.e_lat);
`ifdef FUZZY_SEQ_ROUND_EN
        chk($sformatf("vec%0d out_s8", idx), int'($signed(out_s8)), v.e_round);
`else
        chk($sformatf("vec%0d out_s8", idx), int'($signed(out_s8)), v.e_trunc);
`endif
        chk($sformatf("vec%0d nofire", idx), int'(out_nofire), v.e_nf);
        handshake();
    endtask

    initial begin
        vec_t vecs[11];
        rule_t r1;
        int lat;
        bit seen;

        // {n_on, ia, ib, cons_first, cons_rest, mu_a, mu_b, trunc, round, nofire, latency}
        vecs[0]  = mkv(0, 0, 0,    0,   0, ALL_MAX, ALL_MAX,    0,    0, 1,  9);
        vecs[1]  = mkv(1, 1, 2,  100,   0, {16'd0, 16'd16384, 16'd0}, {16'd32767, 16'd0, 16'd0}, 100, 100, 0, 18);
        vecs[2]  = mkv(2, 0, 0,    1,   0, ALL_MAX, ALL_MAX,    0,    1, 0, 18);
        vecs[3]  = mkv(2, 0, 0,   -1,   0, ALL_MAX, ALL_MAX,    0,   -1, 0, 18);
        vecs[4]  = mkv(9, 0, 0, -128,-128, ALL_MAX, ALL_MAX, -128, -128, 0, 18);
        vecs[5]  = mkv(9, 0, 0,  127, 127, ALL_MAX, ALL_MAX,  127,  127, 0, 18);
        vecs[6]  = mkv(3, 2, 1,  -90,  30, {16'd8000, 16'd0, 16'd0}, {16'd0, 16'd20000, 16'd0}, -10, -10, 0, 18);
        vecs[7]  = mkv(1, 3, 0,   50,   0, ALL_MAX, ALL_MAX,    0,    0, 1,  9);
        vecs[8]  = mkv(1, 0, 0,   50,   0, 48'd0,   ALL_MAX,    0,    0, 1,  9);
        vecs[9]  = mkv(3, 0, 0,  100,  -1, ALL_MAX, ALL_MAX,   32,   33, 0, 18);
        vecs[10] = mkv(3, 0, 0, -100,   1, ALL_MAX, ALL_MAX,  -32,  -33, 0, 18);

        // Reset state
        do_reset();
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset cfg_err", int'(cfg_err), 0);
        chk("reset out_s8", int'(out_s8), 0);
        chk("reset nofire", int'(out_nofire), 0);

        // Out-of-range address in IDLE
        cfg_write(9, 13'h1fff);
        chk("cfg addr9 err", int'(cfg_err), 1);
        tick();
        chk("cfg err one pulse", int'(cfg_err), 0);

        for (int i = 0; i < 11; i++)
            run_vec(i, vecs[i]);

        r1.en = 1'b1; r1.ia = 2'd1; r1.ib = 2'd2; r1.cons = 8'sd100;

        // Backpressure: result held while out_ready is low
        do_reset();
        cfg_write(0, r1);
        accept(vecs[1].ma, vecs[1].mb);
        wait_out(0, lat);
        chk("bp latency", lat, 18);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp out_valid held", int'(out_valid), 1);
            chk("bp out_s8 held", int'($signed(out_s8)), 100);
            chk("bp in_ready low", int'(in_ready), 0);
        end
        handshake();
        chk("bp out_valid drop", int'(out_valid), 0);
        chk("bp in_ready back", int'(in_ready), 1);

        // Config write during EVAL is rejected and leaves the table intact
        accept(vecs[1].ma, vecs[1].mb);
        cfg_write(0, {1'b1, 2'd1, 2'd2, 8'hce});
        chk("eval cfg_err", int'(cfg_err), 1);
        tick();
        chk("eval cfg_err pulse", int'(cfg_err), 0);
        wait_out(2, lat);
        chk("eval latency", lat, 18);
        chk("eval out_s8", int'($signed(out_s8)), 100);
        handshake();
        accept(vecs[1].ma, vecs[1].mb);
        wait_out(0, lat);
        chk("rerun out_s8", int'($signed(out_s8)), 100);
        handshake();

        // cfg_we and in_valid together in IDLE: write wins, sample waits
        do_reset();
        mu_a = vecs[1].ma; mu_b = vecs[1].mb;
        in_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = r1;
        #1;
        chk("conflict in_ready", int'(in_ready), 0);
        tick();
        cfg_we = 1'b0;
        chk("conflict not accepted", int'(busy), 0);
        chk("conflict cfg_err", int'(cfg_err), 0);
        tick();
        in_valid = 1'b0;
        chk("conflict accepted next", int'(busy), 1);
        wait_out(0, lat);
        chk("conflict latency", lat, 18);
        chk("conflict out_s8", int'($signed(out_s8)), 100);
        handshake();

        // Reset during DIV aborts the sample and clears the table
        accept(vecs[1].ma, vecs[1].mb);
        for (int c = 0; c < 12; c++)
            tick();
        chk("pre-reset busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst busy", int'(busy), 0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid)
                seen = 1'b1;
        end
        chk("midrst no out_valid", int'(seen), 0);
        accept(vecs[1].ma, vecs[1].mb);
        wait_out(0, lat);
        chk("cleared latency", lat, 9);
        chk("cleared nofire", int'(out_nofire), 1);
        chk("cleared out_s8", int'($signed(out_s8)), 0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
